game_sched: RTL

//  Basketball game scheduler. Sequences the match: quarters, break intervals, per-team timeouts and the 24 s shot clock.

---
 rtl/game_sched.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/game_sched.sv
// Basketball match sequencer on the 1 Hz game tick: period clock, shot clock,
// per-team timeouts, inter-quarter breaks and the end-of-game hold.
module game_sched #(
  parameter logic [2:0] QUARTERS    = 3'd4,
  parameter logic [7:0] PERIOD_MIN  = 8'h12,
  parameter logic [7:0] SHOT_SEC    = 8'h24,
  parameter logic [7:0] TIMEOUT_SEC = 8'h60,
  parameter logic [7:0] BREAK_SEC   = 8'h15,
  parameter logic [1:0] TO_MAX      = 2'd2
) (
  input  logic       clk_1hz,
  input  logic       sys_rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       to_req_a,
  input  logic       to_req_b,
  input  logic       shot_rst,
  output logic [7:0] game_min,
  output logic [7:0] game_sec,
  output logic [7:0] shot_sec,
  output logic [7:0] aux_sec,
  output logic [2:0] quarter,
  output logic [2:0] state,
  output logic [1:0] to_left_a,
  output logic [1:0] to_left_b,
  output logic       clock_en,
  output logic       buzzer
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StPause   = 3'd2,
    StTimeout = 3'd3,
    StBreak   = 3'd4,
    StOver    = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] game_min_q, game_min_d;
  logic [7:0] game_sec_q, game_sec_d;
  logic [7:0] shot_q, shot_d;
  logic [7:0] aux_q, aux_d;
  logic [2:0] quarter_q, quarter_d;
  logic [1:0] to_left_a_q, to_left_a_d;
  logic [1:0] to_left_b_q, to_left_b_d;
  logic       buzzer_q, buzzer_d;

  // Previous samples of the buttons; an edge is "high now, low last tick".
  logic start_prev_q, pause_prev_q, to_a_prev_q, to_b_prev_q, shot_prev_q;

  logic start_edge, pause_edge, to_a_edge, to_b_edge, shot_edge;
  logic to_a_fire, to_b_fire, period_expire;
  logic run_tick, load_init;
  logic [7:0] gdec_min, gdec_sec;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = 8'h00;
    end else if (v[3:0] == 4'h0) begin
      r = {v[7:4] - 4'h1, 4'h9};
    end else begin
      r = {v[7:4], v[3:0] - 4'h1};
    end
    return r;
  endfunction

  assign start_edge    = start_btn & ~start_prev_q;
  assign pause_edge    = pause_btn & ~pause_prev_q;
  assign to_a_edge     = to_req_a & ~to_a_prev_q;
  assign to_b_edge     = to_req_b & ~to_b_prev_q;
  assign shot_edge     = shot_rst & ~shot_prev_q;
  assign to_a_fire     = to_a_edge && (to_left_a_q != 2'd0);
  assign to_b_fire     = to_b_edge && (to_left_b_q != 2'd0);
  assign period_expire = (game_min_q == 8'h00) && (game_sec_q == 8'h01);

  always_comb begin
    gdec_min = game_min_q;
    gdec_sec = game_sec_q;
    if (game_sec_q != 8'h00) begin
      gdec_sec = bcd_dec(game_sec_q);
    end else if (game_min_q != 8'h00) begin
      gdec_min = bcd_dec(game_min_q);
      gdec_sec = 8'h59;
    end
  end

  always_comb begin
    state_d     = state_q;
    game_min_d  = game_min_q;
    game_sec_d  = game_sec_q;
    shot_d      = shot_q;
    aux_d       = aux_q;
    quarter_d   = quarter_q;
    to_left_a_d = to_left_a_q;
    to_left_b_d = to_left_b_q;
    buzzer_d    = 1'b0;
    run_tick    = 1'b0;
    load_init   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_edge) state_d = StRun;
      end
      StRun: begin
        if (period_expire) begin
          run_tick = 1'b1;
          buzzer_d = 1'b1;
          if (quarter_q < QUARTERS) begin
            state_d = StBreak;
            aux_d   = BREAK_SEC;
          end else begin
            state_d = StOver;
          end
        end else if (to_a_fire) begin
          state_d     = StTimeout;
          to_left_a_d = to_left_a_q - 2'd1;
          aux_d       = TIMEOUT_SEC;
        end else if (to_b_fire) begin
          state_d     = StTimeout;
          to_left_b_d = to_left_b_q - 2'd1;
          aux_d       = TIMEOUT_SEC;
        end else if (pause_edge) begin
          state_d = StPause;
        end else begin
          run_tick = 1'b1;
        end
      end
      StPause: begin
        if (to_a_fire) begin
          state_d     = StTimeout;
          to_left_a_d = to_left_a_q - 2'd1;
          aux_d       = TIMEOUT_SEC;
        end else if (to_b_fire) begin
          state_d     = StTimeout;
          to_left_b_d = to_left_b_q - 2'd1;
          aux_d       = TIMEOUT_SEC;
        end else if (start_edge) begin
          state_d = StRun;
        end
        if (shot_edge) shot_d = SHOT_SEC;
      end
      StTimeout: begin
        aux_d = bcd_dec(aux_q);
        if (aux_q <= 8'h01) begin
          buzzer_d = 1'b1;
          state_d  = StPause;
        end
      end
      StBreak: begin
        aux_d = bcd_dec(aux_q);
        if ((aux_q <= 8'h01) || start_edge) begin
          quarter_d  = quarter_q + 3'd1;
          game_min_d = PERIOD_MIN;
          game_sec_d = 8'h00;
          shot_d     = SHOT_SEC;
          aux_d      = 8'h00;
          state_d    = StPause;
        end
      end
      StOver: begin
        if (start_edge) load_init = 1'b1;
      end
      default: load_init = 1'b1;
    endcase

    if (run_tick) begin
      game_min_d = gdec_min;
      game_sec_d = gdec_sec;
      if (shot_edge) begin
        shot_d = SHOT_SEC;
      end else if (shot_q == 8'h01) begin
        // The shot clock never shows 00: expiry reloads and sounds instead.
        shot_d   = SHOT_SEC;
        buzzer_d = 1'b1;
      end else begin
        shot_d = bcd_dec(shot_q);
      end
    end

    if (load_init) begin
      state_d     = StIdle;
      game_min_d  = PERIOD_MIN;
      game_sec_d  = 8'h00;
      shot_d      = SHOT_SEC;
      aux_d       = 8'h00;
      quarter_d   = 3'd1;
      to_left_a_d = TO_MAX;
      to_left_b_d = TO_MAX;
      buzzer_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_1hz or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q      <= StIdle;
      game_min_q   <= PERIOD_MIN;
      game_sec_q   <= 8'h00;
      shot_q       <= SHOT_SEC;
      aux_q        <= 8'h00;
      quarter_q    <= 3'd1;
      to_left_a_q  <= TO_MAX;
      to_left_b_q  <= TO_MAX;
      buzzer_q     <= 1'b0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      to_a_prev_q  <= 1'b0;
      to_b_prev_q  <= 1'b0;
      shot_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      game_min_q   <= game_min_d;
      game_sec_q   <= game_sec_d;
      shot_q       <= shot_d;
      aux_q        <= aux_d;
      quarter_q    <= quarter_d;
      to_left_a_q  <= to_left_a_d;
      to_left_b_q  <= to_left_b_d;
      buzzer_q     <= buzzer_d;
      start_prev_q <= start_btn;
      pause_prev_q <= pause_btn;
      to_a_prev_q  <= to_req_a;
      to_b_prev_q  <= to_req_b;
      shot_prev_q  <= shot_rst;
    end
  end

  assign game_min  = game_min_q;
  assign game_sec  = game_sec_q;
  assign shot_sec  = shot_q;
  assign aux_sec   = aux_q;
  assign quarter   = quarter_q;
  assign state     = state_q;
  assign to_left_a = to_left_a_q;
  assign to_left_b = to_left_b_q;
  assign clock_en  = (state_q == StRun);
  assign buzzer    = buzzer_q;

endmodule
